// File: rtl/lcd_bus_receiver_pkg.sv
// Shared constants and helpers for the HD44780 4-bit bus receiver:
// command codes, DDRAM line geometry and address-to-shadow-index mapping.
package lcd_bus_receiver_pkg;

    typedef enum logic [1:0] {
        ST_BOOT8 = 2'd0,
        ST_HI    = 2'd1,
        ST_LO    = 2'd2
    } asm_state_e;

    localparam logic [3:0] NIB_MODE4      = 4'h2;

    localparam logic [7:0] CMD_UPPER_MASK = 8'h78;
    localparam int         CMD_SET_ADDR_B = 7;
    localparam int         CMD_ENTRY_B    = 2;
    localparam int         CMD_HOME_B     = 1;
    localparam int         CMD_CLEAR_B    = 0;

    localparam logic [6:0] LINE1_BASE     = 7'h00;
    localparam logic [6:0] LINE2_BASE     = 7'h40;
    localparam logic [6:0] LINE_LEN       = 7'h28;
    localparam logic [6:0] VISIBLE_W      = 7'd16;

    function automatic logic addr_visible(input logic [6:0] a);
        return ((a >= LINE1_BASE) && (a < LINE1_BASE + VISIBLE_W)) ||
               ((a >= LINE2_BASE) && (a < LINE2_BASE + VISIBLE_W));
    endfunction

    function automatic logic [4:0] addr_index(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

    // Steps within a 40-column line and wraps between the two lines.
    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == LINE1_BASE + LINE_LEN - 7'd1) return LINE2_BASE;
            if (a == LINE2_BASE + LINE_LEN - 7'd1) return LINE1_BASE;
            return a + 7'd1;
        end
        if (a == LINE1_BASE) return LINE2_BASE + LINE_LEN - 7'd1;
        if (a == LINE2_BASE) return LINE1_BASE + LINE_LEN - 7'd1;
        return a - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_bus_receiver_nibble_assembler.sv
// Synchronizes the LCD bus, detects E falling edges and pairs nibbles into
// bytes after the 8-bit wake-up sequence.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_BOOT8 | 8-bit wake-up; only RS=0 nibble 0x2 leaves (to 4-bit)
// ST_HI    | waiting for the high nibble of a byte
// ST_LO    | high nibble held; next strobe completes the byte
module lcd_nibble_assembler
    import lcd_bus_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [3:0] sf_data,
    output logic       strobe,
    output logic [7:0] data_byte,
    output logic       byte_is_data,
    output logic       byte_valid,
    output logic       proto_err,
    output logic       mode4
);

    // Bus bits travel together: {E, RS, RW, D7..D4}.
    logic [SYNC_STAGES-1:0][6:0] sync_q, sync_d;
    logic [6:0] bus_now;
    logic       e_prev_q, e_prev_d;
    logic       stb, rs, rw;
    logic [3:0] nib;

    asm_state_e state_q, state_d;
    logic [7:0] data_byte_q, data_byte_d;
    logic       is_data_q, is_data_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic       strobe_q, strobe_d;
    logic       mode4_q, mode4_d;
    logic [3:0] hi_q, hi_d;
    logic       hi_rs_q, hi_rs_d;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], {lcd_e, lcd_rs, lcd_rw, sf_data}};
        bus_now  = sync_q[SYNC_STAGES-1];
        e_prev_d = bus_now[6];
        stb      = e_prev_q & ~bus_now[6];
        rs       = bus_now[5];
        rw       = bus_now[4];
        nib      = bus_now[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT8;
            sync_q      <= '0;
            e_prev_q    <= 1'b0;
            data_byte_q <= 8'h00;
            is_data_q   <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            strobe_q    <= 1'b0;
            mode4_q     <= 1'b0;
            hi_q        <= 4'h0;
            hi_rs_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            e_prev_q    <= e_prev_d;
            data_byte_q <= data_byte_d;
            is_data_q   <= is_data_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            strobe_q    <= strobe_d;
            mode4_q     <= mode4_d;
            hi_q        <= hi_d;
            hi_rs_q     <= hi_rs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stb && !rw) begin
            unique case (state_q)
                ST_BOOT8: if (!rs && nib == NIB_MODE4) state_d = ST_HI;
                ST_HI:    state_d = ST_LO;
                ST_LO:    state_d = ST_HI;
                default:  state_d = ST_BOOT8;
            endcase
        end
    end

    always_comb begin
        data_byte_d = data_byte_q;
        is_data_d   = is_data_q;
        valid_d     = 1'b0;
        err_d       = stb & rw;
        strobe_d    = stb;
        mode4_d     = mode4_q;
        hi_d        = hi_q;
        hi_rs_d     = hi_rs_q;
        if (stb && !rw) begin
            case (state_q)
                ST_BOOT8: if (!rs && nib == NIB_MODE4) mode4_d = 1'b1;
                ST_HI: begin
                    hi_d    = nib;
                    hi_rs_d = rs;
                end
                ST_LO: begin
                    data_byte_d = {hi_q, nib};
                    is_data_d   = rs;
                    valid_d     = 1'b1;
                    err_d       = (rs != hi_rs_q);
                end
                default: ;
            endcase
        end
    end

    assign strobe       = strobe_q;
    assign data_byte    = data_byte_q;
    assign byte_is_data = is_data_q;
    assign byte_valid   = valid_q;
    assign proto_err    = err_q;
    assign mode4        = mode4_q;

endmodule

// File: rtl/lcd_bus_receiver.sv
// HD44780 4-bit bus receiver: command decode, DDRAM address counter,
// clear sweep and a 2x16 shadow of the visible characters.
module lcd_bus_receiver
    import lcd_bus_receiver_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CLEAR_CHAR  = 8'h20
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [3:0] SF_DATA,
    input  logic [4:0] iRdAddr,
    output logic [7:0] oRdChar,
    output logic [7:0] oByte,
    output logic       oByteIsData,
    output logic       oByteValid,
    output logic       oBusy,
    output logic       oProtoErr,
    output logic       oMode4
);

    logic       asm_strobe, asm_err;

    lcd_nibble_assembler #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_asm (
        .clk          (Clock),
        .rst_n        (Reset),
        .lcd_e        (LCD_E),
        .lcd_rs       (LCD_RS),
        .lcd_rw       (LCD_RW),
        .sf_data      (SF_DATA),
        .strobe       (asm_strobe),
        .data_byte    (oByte),
        .byte_is_data (oByteIsData),
        .byte_valid   (oByteValid),
        .proto_err    (asm_err),
        .mode4        (oMode4)
    );

    logic [6:0] addr_q, addr_d;
    logic       inc_q, inc_d;
    logic       busy_q, busy_d;
    logic       boot_q, boot_d;
    logic [4:0] sweep_idx_q, sweep_idx_d;
    logic       err_q, err_d;
    logic [7:0] rd_char_q, rd_char_d;
    logic       we;
    logic [4:0] widx;
    logic [7:0] wdata;
    logic [7:0] cell_q [32];

    always_comb begin
        addr_d      = addr_q;
        inc_d       = inc_q;
        busy_d      = busy_q;
        boot_d      = 1'b0;
        sweep_idx_d = sweep_idx_q;
        we          = 1'b0;
        widx        = sweep_idx_q;
        wdata       = CLEAR_CHAR;
        err_d       = asm_err | (asm_strobe & busy_q);
        rd_char_d   = cell_q[iRdAddr];

        if (boot_q) begin
            busy_d      = 1'b1;
            sweep_idx_d = 5'd0;
        end else if (busy_q) begin
            we          = 1'b1;
            sweep_idx_d = sweep_idx_q + 5'd1;
            if (sweep_idx_q == 5'd31) busy_d = 1'b0;
        end else if (oByteValid) begin
            if (oByteIsData) begin
                if (addr_visible(addr_q)) begin
                    we    = 1'b1;
                    widx  = addr_index(addr_q);
                    wdata = oByte;
                end
                addr_d = addr_step(addr_q, inc_q);
            end else if (oByte[CMD_SET_ADDR_B]) begin
                addr_d = oByte[6:0];
            end else if ((oByte & CMD_UPPER_MASK) == 8'h00) begin
                // Function set / display control / shift fall through untouched.
                if (oByte[CMD_ENTRY_B]) begin
                    inc_d = oByte[1];
                end else if (oByte[CMD_HOME_B]) begin
                    addr_d = LINE1_BASE;
                end else if (oByte[CMD_CLEAR_B]) begin
                    addr_d      = LINE1_BASE;
                    inc_d       = 1'b1;
                    busy_d      = 1'b1;
                    sweep_idx_d = 5'd0;
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            addr_q      <= LINE1_BASE;
            inc_q       <= 1'b1;
            busy_q      <= 1'b0;
            boot_q      <= 1'b1;
            sweep_idx_q <= 5'd0;
            err_q       <= 1'b0;
            rd_char_q   <= 8'h00;
        end else begin
            addr_q      <= addr_d;
            inc_q       <= inc_d;
            busy_q      <= busy_d;
            boot_q      <= boot_d;
            sweep_idx_q <= sweep_idx_d;
            err_q       <= err_d;
            rd_char_q   <= rd_char_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (we) cell_q[widx] <= wdata;
    end

    assign oRdChar   = rd_char_q;
    assign oBusy     = busy_q;
    assign oProtoErr = err_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Bench for lcd_bus_receiver: drives the 4-bit bus, scoreboards assembled
// bytes and compares the shadow buffer against expected contents.
module tb_lcd_bus_receiver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [3:0] sf_data = 4'h0;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_char, byte_out;
    logic       byte_is_data, byte_valid, busy, proto_err, mode4;

    lcd_bus_receiver #(.SYNC_STAGES(2), .CLEAR_CHAR(8'h20)) dut (
        .Clock       (clk),
        .Reset       (rst_n),
        .LCD_E       (lcd_e),
        .LCD_RS      (lcd_rs),
        .LCD_RW      (lcd_rw),
        .SF_DATA     (sf_data),
        .iRdAddr     (rd_addr),
        .oRdChar     (rd_char),
        .oByte       (byte_out),
        .oByteIsData (byte_is_data),
        .oByteValid  (byte_valid),
        .oBusy       (busy),
        .oProtoErr   (proto_err),
        .oMode4      (mode4)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         err_pulses = 0;
    logic [8:0] sb [$];
    logic [8:0] sb_exp;
    logic [7:0] exp_buf [32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (proto_err) err_pulses++;
        if (byte_valid) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                sb_exp = sb.pop_front();
                check("byte", 32'({byte_is_data, byte_out}), 32'(sb_exp));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_nib(input logic r_s, input logic r_w, input logic [3:0] nib);
        @(negedge clk);
        lcd_rs = r_s; lcd_rw = r_w; sf_data = nib;
        tick(2);
        @(negedge clk) lcd_e = 1'b1;
        tick(3);
        @(negedge clk) lcd_e = 1'b0;
        tick(2);
    endtask

    task automatic send_byte(input logic r_s, input logic [7:0] b);
        sb.push_back({r_s, b});
        send_nib(r_s, 1'b0, b[7:4]);
        send_nib(r_s, 1'b0, b[3:0]);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(1'b1, s[i]);
    endtask

    task automatic measure_busy(input string tag);
        int n = 0;
        int w = 0;
        @(negedge clk);
        while (!busy && w < 50) begin @(negedge clk); w++; end
        check({tag, "_busy_seen"}, 32'(busy), 32'd1);
        while (busy && n < 100) begin @(negedge clk); n++; end
        check({tag, "_busy_len"}, 32'(n), 32'd32);
    endtask

    task automatic wake_up();
        for (int i = 0; i < 3; i++) send_nib(1'b0, 1'b0, 4'h3);
        tick(3);
        @(negedge clk);
        check("mode4_after_3", 32'(mode4), 32'd0);
        send_nib(1'b0, 1'b0, 4'h2);
        tick(3);
        @(negedge clk);
        check("mode4_after_4", 32'(mode4), 32'd1);
    endtask

    task automatic check_buf(input string tag);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk) rd_addr = 5'(i);
            @(negedge clk);
            check($sformatf("%s[%0d]", tag, i), 32'(rd_char), 32'(exp_buf[i]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        #1;
        check({tag, "_rdchar"}, 32'(rd_char), 32'd0);
        check({tag, "_byte"},   32'({byte_is_data, byte_out}), 32'd0);
        check({tag, "_valid"},  32'(byte_valid), 32'd0);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_perr"},   32'(proto_err), 32'd0);
        check({tag, "_mode4"},  32'(mode4), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        string msg;
        msg = "Pablo se la come";
        for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;

        tick(3);
        check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        measure_busy("por");

        wake_up();

        send_byte(1'b0, 8'h01);
        measure_busy("clear");
        send_str("AB");
        exp_buf[0] = "A";
        exp_buf[1] = "B";
        tick(4);
        check_buf("ab");

        send_byte(1'b0, 8'hC0);
        send_str(msg);
        for (int i = 0; i < 16; i++) exp_buf[16 + i] = msg[i];

        send_byte(1'b0, 8'h04);
        send_byte(1'b0, 8'h8F);
        send_str("XY");
        exp_buf[15] = "X";
        exp_buf[14] = "Y";

        send_byte(1'b0, 8'h06);
        send_byte(1'b0, 8'hA7);
        send_str("ZQ");
        exp_buf[16] = "Q";
        tick(4);
        check_buf("lines");
        check("no_err_normal", 32'(err_pulses), 32'd0);

        e0 = err_pulses;
        sb.push_back(9'h000);
        send_nib(1'b0, 1'b0, 4'h0);
        send_nib(1'b0, 1'b1, 4'hF);
        send_nib(1'b0, 1'b0, 4'h0);
        tick(4);
        check("rw_err", 32'(err_pulses - e0), 32'd1);

        e0 = err_pulses;
        send_byte(1'b0, 8'h01);
        send_byte(1'b1, "W");
        tick(40);
        check("sweep_err", 32'(err_pulses - e0), 32'd2);
        check("sweep_done", 32'(busy), 32'd0);
        for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
        check_buf("cleared");

        send_nib(1'b1, 1'b0, 4'h4);
        @(negedge clk) rst_n = 1'b0;
        check_reset_outputs("midrst");
        tick(3);
        @(negedge clk) rst_n = 1'b1;
        measure_busy("por2");
        send_nib(1'b0, 1'b0, 4'h4);
        send_nib(1'b0, 1'b0, 4'h1);
        tick(4);
        @(negedge clk);
        check("boot8_after_rst", 32'(mode4), 32'd0);
        check_buf("rst_buf");

        wake_up();
        send_byte(1'b1, "K");
        exp_buf[0] = "K";
        tick(4);
        check_buf("post_rst");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
